// File: rtl/wl_macc.sv
// Pre-add / multiply / accumulate over framed terms; one term per clock, never stalls.
// Result appears 4 edges after the last term; sticky overflow per frame, optional saturation.
module wl_macc #(
   parameter int IW0   = 25,
   parameter int IW1   = 18,
   parameter int OW    = 48,
   parameter int SHIFT = 0,
   parameter int SAT   = 1
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  in_vld,
   input  logic                  in_first,
   input  logic                  in_last,
   input  logic                  sub,
   input  logic signed [IW0-1:0] a,
   input  logic signed [IW0-1:0] d,
   input  logic signed [IW1-1:0] b,
   output logic                  out_vld,
   output logic signed [OW-1:0]  out_p,
   output logic                  out_ovf
);

   localparam int PW = IW0 + 1;
   localparam int MW = IW0 + IW1 + 1;

   localparam logic [OW-1:0] ACC_MAX = {1'b0, {(OW-1){1'b1}}};
   localparam logic [OW-1:0] ACC_MIN = {1'b1, {(OW-1){1'b0}}};

   logic                  s0_vld, s0_first, s0_last, s0_sub;
   logic signed [IW0-1:0] s0_a, s0_d;
   logic signed [IW1-1:0] s0_b;

   logic                  s1_vld, s1_first, s1_last;
   logic signed [PW-1:0]  s1_pre;
   logic signed [IW1-1:0] s1_b;

   logic                  s2_vld, s2_first, s2_last;
   logic signed [MW-1:0]  s2_prod;

   logic signed [OW-1:0]  acc;
   logic                  acc_ovf;
   logic                  s3_fire;

   logic [OW:0]           acc_base;
   logic [OW:0]           sum;
   logic                  ovf_now;
   logic [OW-1:0]         acc_nxt;

   // S0: input capture
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         s0_vld   <= 1'b0;
         s0_first <= 1'b0;
         s0_last  <= 1'b0;
         s0_sub   <= 1'b0;
         s0_a     <= '0;
         s0_d     <= '0;
         s0_b     <= '0;
      end else begin
         s0_vld <= in_vld;
         if (in_vld) begin
            s0_first <= in_first;
            s0_last  <= in_last;
            s0_sub   <= sub;
            s0_a     <= a;
            s0_d     <= d;
            s0_b     <= b;
         end
      end
   end

   // S1: pre-add, one guard bit so d +/- a never overflows
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         s1_vld   <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_pre   <= '0;
         s1_b     <= '0;
      end else begin
         s1_vld <= s0_vld;
         if (s0_vld) begin
            s1_first <= s0_first;
            s1_last  <= s0_last;
            s1_pre   <= s0_sub ? ({s0_d[IW0-1], s0_d} - {s0_a[IW0-1], s0_a})
                               : ({s0_d[IW0-1], s0_d} + {s0_a[IW0-1], s0_a});
            s1_b     <= s0_b;
         end
      end
   end

   // S2: multiply
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         s2_vld   <= 1'b0;
         s2_first <= 1'b0;
         s2_last  <= 1'b0;
         s2_prod  <= '0;
      end else begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_prod  <= s1_pre * s1_b;
         end
      end
   end

   // One extra bit on the sum exposes signed overflow as a sign mismatch
   always_comb begin
      acc_base = s2_first ? '0 : {acc[OW-1], acc};
      sum      = acc_base + {{(OW+1-MW){s2_prod[MW-1]}}, s2_prod};
      ovf_now  = sum[OW] ^ sum[OW-1];
      acc_nxt  = sum[OW-1:0];
      if (ovf_now && (SAT != 0)) begin
         acc_nxt = sum[OW] ? ACC_MIN : ACC_MAX;
      end
   end

   // S3: accumulate
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         acc     <= '0;
         acc_ovf <= 1'b0;
         s3_fire <= 1'b0;
      end else begin
         s3_fire <= s2_vld & s2_last;
         if (s2_vld) begin
            acc     <= acc_nxt;
            acc_ovf <= (acc_ovf & ~s2_first) | ovf_now;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         out_vld <= 1'b0;
         out_p   <= '0;
         out_ovf <= 1'b0;
      end else begin
         out_vld <= s3_fire;
         if (s3_fire) begin
            out_p   <= acc >>> SHIFT;
            out_ovf <= acc_ovf;
         end
      end
   end

endmodule

// File: tb/tb_wl_macc.sv
module tb_wl_macc;

   typedef struct packed {
      logic [47:0] p;
      logic        ovf;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   logic signed [24:0] a = '0, d = '0;
   logic signed [17:0] b = '0;
   logic sub = 1'b0, in_first = 1'b0, in_last = 1'b0;
   bit   vld_any = 1'b0;
   int   vsel = 0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   exp_t sbq [4][$];

   logic [3:0] iv;
   logic [3:0] ov;
   logic [3:0] oo;
   logic signed [47:0] p0, p3;
   logic signed [43:0] p1, p2;
   logic [47:0] op [4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      for (int k = 0; k < 4; k++) iv[k] = vld_any && (vsel == k);
   end

   assign op[0] = p0;
   assign op[1] = {{4{p1[43]}}, p1};
   assign op[2] = {{4{p2[43]}}, p2};
   assign op[3] = p3;

   wl_macc u_def (.clk(clk), .rst_b(rst_b), .in_vld(iv[0]), .in_first(in_first), .in_last(in_last),
                  .sub(sub), .a(a), .d(d), .b(b), .out_vld(ov[0]), .out_p(p0), .out_ovf(oo[0]));
   wl_macc #(.OW(44), .SAT(1)) u_sat (.clk(clk), .rst_b(rst_b), .in_vld(iv[1]), .in_first(in_first),
                  .in_last(in_last), .sub(sub), .a(a), .d(d), .b(b), .out_vld(ov[1]), .out_p(p1), .out_ovf(oo[1]));
   wl_macc #(.OW(44), .SAT(0)) u_wrap (.clk(clk), .rst_b(rst_b), .in_vld(iv[2]), .in_first(in_first),
                  .in_last(in_last), .sub(sub), .a(a), .d(d), .b(b), .out_vld(ov[2]), .out_p(p2), .out_ovf(oo[2]));
   wl_macc #(.SHIFT(4)) u_shf (.clk(clk), .rst_b(rst_b), .in_vld(iv[3]), .in_first(in_first),
                  .in_last(in_last), .sub(sub), .a(a), .d(d), .b(b), .out_vld(ov[3]), .out_p(p3), .out_ovf(oo[3]));

   // Monitor: every out_vld must match the oldest expected result, value and cycle.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (ov[k]) begin
            exp_t e;
            checks++;
            if (sbq[k].size() == 0) begin
               errors++;
               $display("FAIL unexpected_out dut%0d: got p=%0d ovf=%0d at cyc %0d, required no out_vld",
                        k, $signed(op[k]), oo[k], cyc);
            end else begin
               e = sbq[k].pop_front();
               if (e.p !== op[k] || e.ovf !== oo[k] || e.cyc != cyc) begin
                  errors++;
                  $display("FAIL result dut%0d: got p=%0d ovf=%0d cyc=%0d, required p=%0d ovf=%0d cyc=%0d",
                           k, $signed(op[k]), oo[k], cyc, $signed(e.p), e.ovf, e.cyc);
               end
            end
         end
      end
   end

   task automatic term(input int k, input longint dd, input longint aa, input longint bb,
                       input logic s, input logic f, input logic l,
                       input bit ex, input longint ep, input logic eo);
      exp_t e;
      @(negedge clk);
      d = dd[24:0];
      a = aa[24:0];
      b = bb[17:0];
      sub = s;
      in_first = f;
      in_last = l;
      vsel = k;
      vld_any = 1'b1;
      if (ex) begin
         e.p = ep[47:0];
         e.ovf = eo;
         e.cyc = cyc + 5;
         sbq[k].push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         vld_any = 1'b0;
      end
   endtask

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic drain();
      int pend;
      pend = 1;
      for (int i = 0; i < 40 && pend != 0; i++) begin
         idle(1);
         pend = sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size();
      end
      checks++;
      if (pend != 0) begin
         errors++;
         $display("FAIL drain: got %0d results still pending, required 0", pend);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("rst_vld0", longint'(ov[0]), 0);
      chk("rst_p0", $signed(p0), 0);
      chk("rst_ovf0", longint'(oo[0]), 0);
      chk("rst_p1", $signed(p1), 0);
      chk("rst_ovf1", longint'(oo[1]), 0);
      @(negedge clk);
      rst_b = 1'b1;

      // terms before any in_first accumulate onto zero: 5 + 3
      term(0, 5, 0, 1, 0, 0, 0, 0, 0, 0);
      term(0, 3, 0, 1, 0, 0, 1, 1, 8, 0);
      drain();

      // three-term frame: 45 - 20 - 4
      term(0, 10, 5, 3, 0, 1, 0, 0, 0, 0);
      term(0, 7, 2, -4, 1, 0, 0, 0, 0, 0);
      term(0, -1, -1, 2, 0, 0, 1, 1, 21, 0);
      drain();
      idle(3);
      chk("hold_p", $signed(p0), 21);
      chk("hold_ovf", longint'(oo[0]), 0);
      chk("hold_vld", longint'(ov[0]), 0);

      // full-width pre-add: (-2^24 + -2^24) * -2^17 = 2^42
      term(0, -16777216, -16777216, -131072, 0, 1, 1, 1, 64'sd4398046511104, 0);
      drain();

      // back-to-back frames: 2 + 6, then single term 10 * -1
      term(0, 1, 1, 1, 0, 1, 0, 0, 0, 0);
      term(0, 2, 0, 3, 0, 0, 1, 1, 8, 0);
      term(0, 5, 5, -1, 0, 1, 1, 1, -10, 0);
      drain();

      // abandoned frame then bubbly frame: 15 + 24 - 7
      term(0, 4, 1, 2, 0, 1, 0, 0, 0, 0);
      idle(1);
      term(0, 3, 3, 1, 1, 0, 0, 0, 0, 0);
      term(0, 2, 1, 5, 0, 1, 0, 0, 0, 0);
      idle(2);
      term(0, 6, -2, 3, 1, 0, 0, 0, 0, 0);
      idle(1);
      term(0, 1, 0, -7, 0, 0, 1, 1, 32, 0);
      drain();

      // OW=44 saturating: 2^42 three times clamps to 2^43-1
      term(1, -16777216, -16777216, -131072, 0, 1, 0, 0, 0, 0);
      term(1, -16777216, -16777216, -131072, 0, 0, 0, 0, 0, 0);
      term(1, -16777216, -16777216, -131072, 0, 0, 1, 1, 64'sd8796093022207, 1);
      term(1, 1, 1, 1, 0, 1, 1, 1, 2, 0);
      drain();

      // OW=44 wrapping: 2^42 * 3 wraps to -2^42
      term(2, -16777216, -16777216, -131072, 0, 1, 0, 0, 0, 0);
      term(2, -16777216, -16777216, -131072, 0, 0, 0, 0, 0, 0);
      term(2, -16777216, -16777216, -131072, 0, 0, 1, 1, -64'sd4398046511104, 1);
      term(2, 3, 0, 5, 0, 1, 1, 1, 15, 0);
      drain();

      // SHIFT=4: -37 >>> 4 = -3, 37 >>> 4 = 2
      term(3, -20, 0, 1, 0, 1, 0, 0, 0, 0);
      term(3, -17, 0, 1, 0, 0, 1, 1, -3, 0);
      term(3, 37, 0, 1, 0, 1, 1, 1, 2, 0);
      drain();

      // reset with two terms in flight: nothing may emerge afterwards
      term(0, 9, 0, 1, 0, 1, 0, 0, 0, 0);
      term(0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      vld_any = 1'b0;
      #1 rst_b = 1'b0;
      #1;
      chk("midrst_p0", $signed(p0), 0);
      chk("midrst_vld0", longint'(ov[0]), 0);
      chk("midrst_p2", $signed(p2), 0);
      chk("midrst_p3", $signed(p3), 0);
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      idle(8);
      chk("postrst_p0", $signed(p0), 0);

      term(0, 2, 0, 2, 0, 1, 0, 0, 0, 0);
      term(0, 1, 0, 3, 0, 0, 1, 1, 7, 0);
      drain();
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wl_macc.md
WL_MACC -- requirements
Module: wl_macc

Interface
REQ-001 Parameter IW0, default 25, signed pre-adder operand width (a, d); legal 2..25.
REQ-002 Parameter IW1, default 18, signed multiplier operand width (b); legal 2..18.
REQ-003 Parameter OW, default 48, signed accumulator/output width; SHALL satisfy OW >= IW0+IW1+1 and OW <= 48.
REQ-004 Parameter SHIFT, default 0, arithmetic right shift applied to the final sum; legal 0..OW-2.
REQ-005 Parameter SAT, default 1: 1 = saturate accumulator on overflow, 0 = two's-complement wrap.
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 rst_b  in  1  asynchronous active-low reset.
REQ-008 in_vld  in  1  input term valid; a, d, b, sub, in_first, in_last are sampled only when high.
REQ-009 in_first  in  1  term is the first of a frame.
REQ-010 in_last  in  1  term is the last of a frame.
REQ-011 sub  in  1  pre-adder mode: 0 = d+a, 1 = d-a.
REQ-012 a  in  IW0  signed pre-adder operand.
REQ-013 d  in  IW0  signed pre-adder operand.
REQ-014 b  in  IW1  signed multiplier operand.
REQ-015 out_vld  out  1  one-cycle pulse, out_p/out_ovf valid.
REQ-016 out_p  out  OW  signed frame result, (sum >>> SHIFT), sign-extended to OW.
REQ-017 out_ovf  out  1  frame accumulator overflowed at least once.

Function
REQ-018 Pipeline SHALL be 4 registered stages: S0 input capture, S1 pre-add (IW0+1 bits, no overflow), S2 multiply (IW0+IW1+1 bits), S3 accumulate, followed by output register; in_vld/in_first/in_last/sub travel with the data.
REQ-019 Input to output latency SHALL be fixed: out_vld asserts on the 4th rising edge after the edge sampling the in_last term; no stall, one term accepted per clock.
REQ-020 Term with in_first=1 SHALL load acc = sign-extended product and clear the sticky overflow flag; otherwise acc = acc + product.
REQ-021 Cycles with in_vld=0 (bubbles) SHALL leave acc, flag and outputs unchanged except out_vld=0.
REQ-022 Signed overflow of acc+product SHALL set the sticky flag; with SAT=1 acc clamps to +2^(OW-1)-1 or -2^(OW-1) and further terms continue from the clamped value; with SAT=0 acc wraps.
REQ-023 Term with in_first=1 and in_last=1 SHALL form a single-term frame and produce one result.
REQ-024 in_first arriving before in_last of the previous frame SHALL discard the partial sum; no out_vld for the abandoned frame.
REQ-025 Terms with in_vld=1 before any in_first since reset SHALL accumulate onto zero.
REQ-026 out_p and out_ovf SHALL hold the last result until the next out_vld.
REQ-027 Back-to-back frames (in_last then in_first on consecutive cycles) SHALL produce results on consecutive-frame timing with no lost terms.

Reset
REQ-028 rst_b low SHALL immediately clear all pipeline registers, acc, sticky flag, out_vld=0, out_p=0, out_ovf=0, and all in-flight terms are dropped.
REQ-029 Reset deassertion mid-frame SHALL leave no residue; first result thereafter depends only on post-reset terms.

Verification
REQ-030 Defaults, frame of 3 terms (d,a,b,sub) = (10,5,3,0),(7,2,-4,1),(-1,-1,2,0) -> single out_vld 4 edges after last term, out_p=45-20-4=21, out_ovf=0.
REQ-031 Single-term frame d=-16777216, a=-16777216, b=-131072, sub=0 -> out_p=+4398046511104, out_ovf=0 (full-width pre-add, no overflow).
REQ-032 OW=44, SAT=1, repeated max-positive products until overflow -> out_p=+2^43-1, out_ovf=1; SAT=0 same stimulus -> wrapped value, out_ovf=1; next frame out_ovf=0.
REQ-033 SHIFT=4, frame sum -37 -> out_p=-3 (arithmetic shift, floor).
REQ-034 Frame with bubbles between terms and an abandoned frame (in_first repeated) -> only completed frame reported, value matches bubble-free reference model.
REQ-035 rst_b pulsed low mid-frame with 2 terms in flight -> outputs 0 at once, no out_vld after release, next frame result correct.
